// File: rtl/vram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : vram_pkg                                                 |
// | Purpose  : Shared sizes, FSM states and grant codes for the text-   |
// |            mode VRAM arbiter.                                       |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package vram_pkg;

   localparam int VRAM_ADDR_W = 11;
   localparam int VRAM_DATA_W = 32;
   localparam int VRAM_WORDS  = 1200;

   // IDLE arbitrates every cycle; RD_WAIT is the CPU read-data return cycle.
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_t;

   // Owner of the RAM port in the current cycle.
   typedef enum logic [1:0] {
      GNT_NONE   = 2'd0,
      GNT_VGA    = 2'd1,
      GNT_CPU_RD = 2'd2,
      GNT_CPU_WR = 2'd3
   } arb_grant_t;

   function automatic logic is_cpu_grant(input arb_grant_t g);
      return (g == GNT_CPU_RD) || (g == GNT_CPU_WR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vram_arb_guard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : vram_arb_guard                                           |
// | Purpose  : Counts IDLE cycles a pending CPU request loses to VGA    |
// |            and raises force_cpu once MAX_CPU_WAIT losses are seen.  |
// |            Only instantiated when VRAM_ARB_CPU_GUARD_EN is defined. |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module vram_arb_guard #(
   parameter int MAX_CPU_WAIT = 4
) (
   input  logic Clk,
   input  logic RESET,
   input  logic cpu_req,
   input  logic cpu_lost,
   input  logic cpu_grant,
   output logic force_cpu
);

   // A zero limit still needs a one-bit counter.
   localparam int               CNT_W      = (MAX_CPU_WAIT < 1) ? 1 : $clog2(MAX_CPU_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_CPU_WAIT);

   logic [CNT_W-1:0] wait_cnt;

   // Loss counter: restarts whenever the CPU is served or withdraws, saturates at the limit.
   always_ff @(posedge Clk) begin
      if (RESET || !cpu_req || cpu_grant) begin
         wait_cnt <= '0;
      end else if (cpu_lost && (wait_cnt != WAIT_LIMIT)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign force_cpu = cpu_req && (wait_cnt == WAIT_LIMIT);

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : vram_arbiter                                             |
// | Purpose  : Single-port VRAM arbiter between the Avalon-MM CPU slave |
// |            and the VGA character fetch port. VGA has priority; the  |
// |            optional CPU wait guard is enabled by defining           |
// |            VRAM_ARB_CPU_GUARD_EN.                                   |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W       = VRAM_ADDR_W,
   parameter int DATA_W       = VRAM_DATA_W,
   parameter int MAX_CPU_WAIT = 4
) (
   input  logic                  Clk,
   input  logic                  RESET,
   input  logic                  AVL_CS,
   input  logic                  AVL_READ,
   input  logic                  AVL_WRITE,
   input  logic [ADDR_W-1:0]     AVL_ADDR,
   input  logic [DATA_W/8-1:0]   AVL_BYTE_EN,
   input  logic [DATA_W-1:0]     AVL_WRITEDATA,
   output logic [DATA_W-1:0]     AVL_READDATA,
   output logic                  AVL_WAITREQUEST,
   input  logic                  fetch_req,
   input  logic [ADDR_W-1:0]     fetch_addr,
   output logic                  fetch_ack,
   output logic                  fetch_valid,
   output logic [DATA_W-1:0]     fetch_data,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_wren,
   output logic [DATA_W/8-1:0]   mem_byteen,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   arb_state_t        state;
   arb_state_t        next_state;
   arb_grant_t        grant;
   logic              cpu_req;
   logic              cpu_wr;
   logic              cpu_grant;
   logic              cpu_lost;
   logic              force_cpu;
   logic              rd_done;
   logic              fetch_valid_q;
   logic [ADDR_W-1:0] last_addr;

   // A simultaneous read+write is treated as a write.
   assign cpu_req   = AVL_CS & (AVL_READ | AVL_WRITE);
   assign cpu_wr    = AVL_CS & AVL_WRITE;
   assign cpu_grant = is_cpu_grant(grant);
   assign cpu_lost  = (state == IDLE) && cpu_req && (grant == GNT_VGA);

`ifdef VRAM_ARB_CPU_GUARD_EN
   vram_arb_guard #(
      .MAX_CPU_WAIT (MAX_CPU_WAIT)
   ) u_guard (
      .Clk       (Clk),
      .RESET     (RESET),
      .cpu_req   (cpu_req),
      .cpu_lost  (cpu_lost),
      .cpu_grant (cpu_grant),
      .force_cpu (force_cpu)
   );
`else
   logic unused_guard_cfg;
   assign force_cpu        = 1'b0;
   assign unused_guard_cfg = (MAX_CPU_WAIT == 0) | cpu_lost;
`endif

   // State register; reset abandons any read in flight.
   always_ff @(posedge Clk) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Arbitration and next state; nothing is granted while RESET is high.
   always_comb begin
      next_state = state;
      grant      = GNT_NONE;
      if (!RESET) begin
         unique case (state)
            IDLE: begin
               if (force_cpu) begin
                  grant = cpu_wr ? GNT_CPU_WR : GNT_CPU_RD;
               end else if (fetch_req) begin
                  grant = GNT_VGA;
               end else if (cpu_req) begin
                  grant = cpu_wr ? GNT_CPU_WR : GNT_CPU_RD;
               end
               if (grant == GNT_CPU_RD) begin
                  next_state = RD_WAIT;
               end
            end
            RD_WAIT: begin
               // The RAM port is idle while read data returns, so VGA may use it.
               if (fetch_req) begin
                  grant = GNT_VGA;
               end
               next_state = IDLE;
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // RAM port drive; the address holds its last value when nobody is granted.
   always_comb begin
      mem_addr   = last_addr;
      mem_wren   = 1'b0;
      mem_byteen = '0;
      fetch_ack  = 1'b0;
      unique case (grant)
         GNT_VGA: begin
            mem_addr  = fetch_addr;
            fetch_ack = 1'b1;
         end
         GNT_CPU_RD: begin
            mem_addr = AVL_ADDR;
         end
         GNT_CPU_WR: begin
            mem_addr   = AVL_ADDR;
            mem_wren   = 1'b1;
            mem_byteen = AVL_BYTE_EN;
         end
         default: begin
         end
      endcase
   end

   // Fetch data-valid pipeline and remembered RAM address.
   always_ff @(posedge Clk) begin
      if (RESET) begin
         fetch_valid_q <= 1'b0;
         last_addr     <= '0;
      end else begin
         fetch_valid_q <= fetch_ack;
         last_addr     <= mem_addr;
      end
   end

   assign rd_done         = (state == RD_WAIT) && !RESET;
   assign AVL_WAITREQUEST = cpu_req & ~((grant == GNT_CPU_WR) | rd_done);
   assign AVL_READDATA    = mem_rdata;
   assign fetch_valid     = fetch_valid_q;
   assign fetch_data      = mem_rdata;
   assign mem_wdata       = AVL_WRITEDATA;

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port arbiter that shares the text-mode VRAM (one on-chip RAM block, synchronous read, one-cycle read latency) between the Avalon-MM CPU slave and the VGA character fetch port. It sits between the Avalon interconnect, the text drawer and the RAM macro. It replaces per-requester read/write/fetch sequencing with cycle-level grants. The VGA port has deadline priority, and an optional wait guard bounds CPU stall time.

## Interface
- ADDR_W, 11, VRAM word address width (1200 words used)
- DATA_W, 32, VRAM word width
- MAX_CPU_WAIT, 4, cycles a pending CPU request may lose to VGA before it is forced through (guard build only)

- Clk  in  1  system clock
- RESET  in  1  synchronous, active-high
- AVL_CS  in  1  Avalon chip select
- AVL_READ  in  1  Avalon read request
- AVL_WRITE  in  1  Avalon write request
- AVL_ADDR  in  ADDR_W  Avalon word address
- AVL_BYTE_EN  in  DATA_W/8  write byte enables
- AVL_WRITEDATA  in  DATA_W  write data
- AVL_READDATA  out  DATA_W  read data, valid when a read completes
- AVL_WAITREQUEST  out  1  stall; transfer completes in the cycle it is low
- fetch_req  in  1  VGA fetch request
- fetch_addr  in  ADDR_W  VGA fetch word address
- fetch_ack  out  1  fetch issued to RAM this cycle
- fetch_valid  out  1  fetch_data valid; the cycle after fetch_ack
- fetch_data  out  DATA_W  fetched word
- mem_addr  out  ADDR_W  RAM address
- mem_wren  out  1  RAM write enable
- mem_byteen  out  DATA_W/8  RAM byte enables
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one cycle after address

## Operation
- cpu_req = AVL_CS & (AVL_READ | AVL_WRITE). If AVL_READ and AVL_WRITE are both high, the request is a write and the read is ignored.
- FSM states:
  - IDLE: arbitrate each cycle.
  - RD_WAIT: CPU read data returning.
- IDLE grant order:
  - Forced CPU, when the guard has tripped.
  - Otherwise fetch_req wins.
  - Otherwise cpu_req.
- VGA grant: mem_addr=fetch_addr, fetch_ack=1. The FSM stays in IDLE, so back-to-back fetches sustain one word per cycle.
- CPU write grant: mem_wren=1, mem_byteen=AVL_BYTE_EN, AVL_WAITREQUEST=0 in the same cycle. The FSM stays in IDLE.
- CPU read grant: mem_addr=AVL_ADDR, AVL_WAITREQUEST stays 1, then the FSM goes to RD_WAIT.
- RD_WAIT behaviour:
  - AVL_READDATA=mem_rdata and AVL_WAITREQUEST=0.
  - The RAM port is free, so a fetch_req may be issued (fetch_ack=1).
  - A new CPU request is not accepted in this state.
  - The FSM always returns to IDLE.
- fetch_valid is a register loaded from fetch_ack. fetch_data=mem_rdata.
- AVL_WAITREQUEST=1 whenever cpu_req is high and the request is not completing this cycle. It is 0 when cpu_req is low.
- When no grant is made: mem_wren=0, mem_byteen=0, mem_addr holds its last value.

## Timing
- Reset values:
  - state=IDLE, fetch_valid=0, fetch_ack=0, mem_wren=0, wait counter=0.
  - AVL_WAITREQUEST=cpu_req (no completions occur during RESET).
- Latencies:
  - Write: 0 extra cycles when uncontended.
  - Read: completes 1 cycle after grant.
  - Fetch: data 1 cycle after fetch_ack.
- Reset during RD_WAIT: the read is aborted with no completion, and fetch_valid clears the next cycle.
- Simultaneous fetch_req and cpu_req without guard trip: VGA is served and the CPU stalls.

## Configuration
- VRAM_ARB_CPU_GUARD_EN defined:
  - A counter of width clog2(MAX_CPU_WAIT+1) increments each IDLE cycle in which cpu_req loses to fetch_req.
  - At MAX_CPU_WAIT, the CPU wins the next IDLE arbitration. That fetch is delayed one cycle (fetch_ack=0).
  - The counter clears on any CPU grant or when cpu_req is low.
- VRAM_ARB_CPU_GUARD_EN undefined: strict VGA priority, no counter, and the CPU may stall indefinitely.

## Structure
- Shared package vram_pkg holds:
  - VRAM_ADDR_W, VRAM_DATA_W, VRAM_WORDS=1200.
  - enum arb_state_t {IDLE, RD_WAIT}.
  - Grant enum {GNT_NONE, GNT_VGA, GNT_CPU_RD, GNT_CPU_WR}.
- One natural sub-module: vram_arb_guard (wait counter plus force flag), instantiated only under the macro.

## Test plan
- CPU write to addr 0x010, data 0xDEADBEEF, byte_en 0xF, no fetch -> mem_wren=1 and AVL_WAITREQUEST=0 in the same cycle. A later read of 0x010 returns 0xDEADBEEF one cycle after grant.
- Continuous fetch_req over addrs 0..79 -> 80 consecutive fetch_ack. fetch_valid follows each ack by 1 cycle with the correct data.
- CPU read during continuous fetch, guard off -> AVL_WAITREQUEST held high until fetch_req drops. The read then completes 1 cycle after grant.
- Same stimulus with the guard on and MAX_CPU_WAIT=4 -> CPU granted on the 5th contended cycle, and fetch_ack=0 for exactly that cycle.
- RESET asserted in RD_WAIT -> no completion. Next cycle: state IDLE, fetch_valid=0, AVL_WAITREQUEST=1 while the read stays asserted.
- AVL_READ and AVL_WRITE both high at addr 0x020 -> a write is performed and the FSM stays in IDLE.
